// File: rtl/dcache_wb2way_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcache_wb2way_pkg
// Brief  : Shared types for the 2-way write-back data cache: controller
//          states, default address layout and the per-frame record.
// Rev    : 1.0  initial release
// ============================================================================
package dcache_wb2way_pkg;

    // Default geometry; the cache itself is parameterised on NSETS.
    localparam int DC_NSETS_DEF = 8;
    localparam int DC_IDXW_DEF  = $clog2(DC_NSETS_DEF);
    // Widest tag any legal geometry needs (NSETS = 2 leaves 28 tag bits).
    localparam int DC_TAGW_MAX  = 28;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WB0    = 4'd1,
        WB1    = 4'd2,
        LD0    = 4'd3,
        LD1    = 4'd4,
        FL_CHK = 4'd5,
        FL_W0  = 4'd6,
        FL_W1  = 4'd7,
        DONE   = 4'd8
    } dcache_state_t;

    // Byte address split for the default geometry.
    typedef struct packed {
        logic [31-DC_IDXW_DEF-3:0] tag;
        logic [DC_IDXW_DEF-1:0]    idx;
        logic                      blkoff;
        logic [1:0]                bytoff;
    } dcache_addr_t;

    // One cache frame; tags narrower than DC_TAGW_MAX are zero-extended.
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [DC_TAGW_MAX-1:0] tag;
        logic [1:0][31:0]       word;
    } dcache_frame_t;

endpackage
`default_nettype wire

// File: rtl/dcache_wb2way_if.sv
`default_nettype none
// ============================================================================
// Module : dcache_wb2way_if
// Brief  : Datapath-side request bus and word-wide memory port of the cache.
//          The cache uses the slave view, the surrounding system the master.
// Rev    : 1.0  initial release
// ============================================================================
interface dcache_wb2way_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output dhit, dmemload, flushed,
        output dREN, dWEN, daddr, dstore,
        input  dwait, dload
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  dhit, dmemload, flushed,
        input  dREN, dWEN, daddr, dstore,
        output dwait, dload
    );
endinterface
`default_nettype wire

// File: rtl/dcache_wb2way_array.sv
`default_nettype none
// ============================================================================
// Module : dcache_wb2way_array
// Brief  : Frame and LRU storage. Two asynchronous read ports (request set,
//          flush frame) and two write ports (hit/flush update, refill).
// Rev    : 1.0  initial release
// ============================================================================
module dcache_wb2way_array
    import dcache_wb2way_pkg::*;
#(
    parameter int NSETS = 8,
    parameter int IDXW  = $clog2(NSETS)
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    // request-set read port
    input  wire logic [IDXW-1:0]        rd_idx,
    output dcache_frame_t               rd_frame [2],
    output logic                        rd_lru,
    // flush read port
    input  wire logic                   fl_way,
    input  wire logic [IDXW-1:0]        fl_idx,
    output dcache_frame_t               fl_frame,
    // update port: store hit writes a word and sets dirty, flush clears dirty
    input  wire logic                   upd_we,
    input  wire logic                   upd_clr_dirty,
    input  wire logic                   upd_way,
    input  wire logic [IDXW-1:0]        upd_idx,
    input  wire logic                   upd_sel,
    input  wire logic [31:0]            upd_data,
    // LRU update for the request set
    input  wire logic                   lru_we,
    input  wire logic                   lru_val,
    // refill port: word 0 invalidates the frame, word 1 validates it
    input  wire logic                   fill_we,
    input  wire logic                   fill_way,
    input  wire logic [IDXW-1:0]        fill_idx,
    input  wire logic                   fill_sel,
    input  wire logic [31:0]            fill_data,
    input  wire logic [DC_TAGW_MAX-1:0] fill_tag
);

    logic                   valid_q [2][NSETS];
    logic                   valid_d [2][NSETS];
    logic                   dirty_q [2][NSETS];
    logic                   dirty_d [2][NSETS];
    logic                   lru_q   [NSETS];
    logic                   lru_d   [NSETS];
    logic [DC_TAGW_MAX-1:0] tag_q   [2][NSETS];
    logic [DC_TAGW_MAX-1:0] tag_d   [2][NSETS];
    logic [1:0][31:0]       word_q  [2][NSETS];
    logic [1:0][31:0]       word_d  [2][NSETS];

    // Next-state of the status bits (valid, dirty, LRU).
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        lru_d   = lru_q;
        if (upd_we)        dirty_d[upd_way][upd_idx] = 1'b1;
        if (upd_clr_dirty) dirty_d[upd_way][upd_idx] = 1'b0;
        if (lru_we)        lru_d[rd_idx] = lru_val;
        if (fill_we) begin
            valid_d[fill_way][fill_idx] = fill_sel;
            dirty_d[fill_way][fill_idx] = 1'b0;
        end
    end

    // Next-state of the tag and data payload.
    always_comb begin
        tag_d  = tag_q;
        word_d = word_q;
        if (upd_we) word_d[upd_way][upd_idx][upd_sel] = upd_data;
        if (fill_we) begin
            word_d[fill_way][fill_idx][fill_sel] = fill_data;
            tag_d[fill_way][fill_idx]            = fill_tag;
        end
    end

    // Status bits reset so the cache starts empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < NSETS; s++) begin
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
                dirty_q[0][s] <= 1'b0;
                dirty_q[1][s] <= 1'b0;
                lru_q[s]      <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            lru_q   <= lru_d;
        end
    end

    // Payload storage is never reset; valid gates its use.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        word_q <= word_d;
    end

    // Asynchronous read of both ways of the request set and of the flush frame.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            rd_frame[w].valid = valid_q[w][rd_idx];
            rd_frame[w].dirty = dirty_q[w][rd_idx];
            rd_frame[w].tag   = tag_q[w][rd_idx];
            rd_frame[w].word  = word_q[w][rd_idx];
        end
        rd_lru         = lru_q[rd_idx];
        fl_frame.valid = valid_q[fl_way][fl_idx];
        fl_frame.dirty = dirty_q[fl_way][fl_idx];
        fl_frame.tag   = tag_q[fl_way][fl_idx];
        fl_frame.word  = word_q[fl_way][fl_idx];
    end

endmodule
`default_nettype wire

// File: rtl/dcache_wb2way.sv
`default_nettype none
// ============================================================================
// Module : dcache_wb2way
// Brief  : Write-back 2-way set-associative data cache with LRU replacement,
//          two-word blocks and a halt-triggered flush of all dirty frames.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_wb2way
    import dcache_wb2way_pkg::*;
#(
    parameter int NSETS = 8
) (
    input wire logic      CLK,
    input wire logic      RST,
    dcache_wb2way_if.slave bus
);

    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 32 - IDXW - 3;
    localparam int FIW  = IDXW + 1;

    dcache_state_t  state_q, state_d;
    logic           way_q, way_d;
    logic [FIW-1:0] fi_q, fi_d;

    logic [TAGW-1:0] req_tag;
    logic [IDXW-1:0] req_idx;
    logic            req_blk;
    logic            req;
    assign req_tag = bus.dmemaddr[31:IDXW+3];
    assign req_idx = bus.dmemaddr[IDXW+2:3];
    assign req_blk = bus.dmemaddr[2];
    assign req     = bus.dmemREN | bus.dmemWEN;

    dcache_frame_t    rd_frame [2];
    dcache_frame_t    fl_frame;
    logic             rd_lru;
    logic             fl_way;
    logic [IDXW-1:0]  fl_idx;
    assign fl_way = fi_q[IDXW];
    assign fl_idx = fi_q[IDXW-1:0];

    logic             upd_we, upd_clr_dirty, upd_way, upd_sel;
    logic [IDXW-1:0]  upd_idx;
    logic             lru_we, lru_val;
    logic             fill_we, fill_sel;

    logic [1:0] way_match;
    logic       hit_way;
    logic       any_hit;

    logic        dhit, flushed, dren, dwen;
    logic [31:0] dmemload, daddr, dstore;

    logic unused_bits;
    assign unused_bits = ^{bus.dmemaddr[1:0], rd_frame[0].tag, rd_frame[1].tag,
                           rd_frame[0].dirty, fl_frame.tag};

    dcache_wb2way_array #(.NSETS(NSETS), .IDXW(IDXW)) u_array (
        .CLK           (CLK),
        .RST           (RST),
        .rd_idx        (req_idx),
        .rd_frame      (rd_frame),
        .rd_lru        (rd_lru),
        .fl_way        (fl_way),
        .fl_idx        (fl_idx),
        .fl_frame      (fl_frame),
        .upd_we        (upd_we),
        .upd_clr_dirty (upd_clr_dirty),
        .upd_way       (upd_way),
        .upd_idx       (upd_idx),
        .upd_sel       (upd_sel),
        .upd_data      (bus.dmemstore),
        .lru_we        (lru_we),
        .lru_val       (lru_val),
        .fill_we       (fill_we),
        .fill_way      (way_q),
        .fill_idx      (req_idx),
        .fill_sel      (fill_sel),
        .fill_data     (bus.dload),
        .fill_tag      (DC_TAGW_MAX'(req_tag))
    );

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign way_match[w] = rd_frame[w].valid && (rd_frame[w].tag[TAGW-1:0] == req_tag);
    end
    assign any_hit = |way_match;
    assign hit_way = ~way_match[0];

    // Controller state, victim way and flush frame counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            way_q   <= 1'b0;
            fi_q    <= '0;
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            fi_q    <= fi_d;
        end
    end

    // Next state, memory-port drive and array write controls.
    always_comb begin
        state_d       = state_q;
        way_d         = way_q;
        fi_d          = fi_q;
        dhit          = 1'b0;
        dmemload      = '0;
        flushed       = 1'b0;
        dren          = 1'b0;
        dwen          = 1'b0;
        daddr         = '0;
        dstore        = '0;
        upd_we        = 1'b0;
        upd_clr_dirty = 1'b0;
        upd_way       = hit_way;
        upd_idx       = req_idx;
        upd_sel       = req_blk;
        lru_we        = 1'b0;
        lru_val       = 1'b0;
        fill_we       = 1'b0;
        fill_sel      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (any_hit) begin
                        dhit     = 1'b1;
                        dmemload = rd_frame[hit_way].word[req_blk];
                        lru_we   = 1'b1;
                        lru_val  = ~hit_way;
                        upd_we   = bus.dmemWEN;
                    end else begin
                        way_d   = rd_lru;
                        state_d = (rd_frame[rd_lru].valid && rd_frame[rd_lru].dirty) ? WB0 : LD0;
                    end
                end else if (bus.halt) begin
                    fi_d    = '0;
                    state_d = FL_CHK;
                end
            end
            WB0: begin
                dwen   = 1'b1;
                daddr  = {rd_frame[way_q].tag[TAGW-1:0], req_idx, 3'b000};
                dstore = rd_frame[way_q].word[0];
                if (!bus.dwait) state_d = WB1;
            end
            WB1: begin
                dwen   = 1'b1;
                daddr  = {rd_frame[way_q].tag[TAGW-1:0], req_idx, 3'b100};
                dstore = rd_frame[way_q].word[1];
                if (!bus.dwait) state_d = LD0;
            end
            LD0: begin
                dren  = 1'b1;
                daddr = {req_tag, req_idx, 3'b000};
                if (!bus.dwait) begin
                    fill_we = 1'b1;
                    state_d = LD1;
                end
            end
            LD1: begin
                dren  = 1'b1;
                daddr = {req_tag, req_idx, 3'b100};
                if (!bus.dwait) begin
                    fill_we  = 1'b1;
                    fill_sel = 1'b1;
                    state_d  = IDLE;
                end
            end
            FL_CHK: begin
                if (fl_frame.valid && fl_frame.dirty) begin
                    state_d = FL_W0;
                end else if (fi_q == '1) begin
                    state_d = DONE;
                end else begin
                    fi_d = fi_q + 1'b1;
                end
            end
            FL_W0: begin
                dwen   = 1'b1;
                daddr  = {fl_frame.tag[TAGW-1:0], fl_idx, 3'b000};
                dstore = fl_frame.word[0];
                if (!bus.dwait) state_d = FL_W1;
            end
            FL_W1: begin
                dwen   = 1'b1;
                daddr  = {fl_frame.tag[TAGW-1:0], fl_idx, 3'b100};
                dstore = fl_frame.word[1];
                if (!bus.dwait) begin
                    upd_clr_dirty = 1'b1;
                    upd_way       = fl_way;
                    upd_idx       = fl_idx;
                    if (fi_q == '1) begin
                        state_d = DONE;
                    end else begin
                        fi_d    = fi_q + 1'b1;
                        state_d = FL_CHK;
                    end
                end
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dhit     = dhit;
    assign bus.dmemload = dmemload;
    assign bus.flushed  = flushed;
    assign bus.dREN     = dren;
    assign bus.dWEN     = dwen;
    assign bus.daddr    = daddr;
    assign bus.dstore   = dstore;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb2way.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_wb2way
// Brief  : Directed bench for dcache_wb2way with a word-wide memory model and
//          a queue of expected memory transfers.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dcache_wb2way;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dcache_wb2way_if bus();

    dcache_wb2way #(.NSETS(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;
    xfer_t exp_q[$];

    int          mem_wait = 2;
    int          wait_cnt = 0;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_xfer(input logic we, input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.we   = we;
        x.addr = a;
        x.data = d;
        exp_q.push_back(x);
    endtask

    // Memory model: each transfer waits mem_wait cycles, then completes.
    initial begin
        xfer_t e;
        bus.dwait = 1'b1;
        bus.dload = '0;
        forever begin
            @(negedge CLK);
            #2;
            if (RST || !(bus.dREN || bus.dWEN)) begin
                wait_cnt  = 0;
                bus.dwait = 1'b1;
            end else if (wait_cnt < mem_wait) begin
                wait_cnt++;
                bus.dwait = 1'b1;
            end else begin
                wait_cnt  = 0;
                bus.dwait = 1'b0;
                chk("xfer_onehot", 32'(bus.dREN & bus.dWEN), 32'd0);
                chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("xfer_kind", 32'(bus.dWEN), 32'(e.we));
                    chk("xfer_addr", bus.daddr, e.addr);
                    if (e.we) chk("xfer_data", bus.dstore, e.data);
                end
                if (bus.dREN) bus.dload = rd_mem(bus.daddr);
                else          mem[bus.daddr] = bus.dstore;
            end
        end
    end

    task automatic access(input string tag, input logic ren, input logic wen,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_load, input int exp_lat);
        int lat = 0;
        @(negedge CLK);
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
        #1;
        while (!bus.dhit && lat < 60) begin
            @(negedge CLK);
            #1;
            lat++;
        end
        chk({tag, "_hit"}, 32'(bus.dhit), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (ren && !wen) chk({tag, "_load"}, bus.dmemload, exp_load);
        @(negedge CLK);
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    initial begin
        int n;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;
        mem[32'h100]  = 32'hDEAD_BEEF;
        mem[32'h104]  = 32'hCAFE_F00D;

        // Outputs while reset is held.
        @(negedge CLK);
        #1;
        chk("rst_dhit",     32'(bus.dhit),    32'd0);
        chk("rst_flushed",  32'(bus.flushed), 32'd0);
        chk("rst_dren",     32'(bus.dREN),    32'd0);
        chk("rst_dwen",     32'(bus.dWEN),    32'd0);
        chk("rst_daddr",    bus.daddr,        32'd0);
        chk("rst_dstore",   bus.dstore,       32'd0);
        chk("rst_dmemload", bus.dmemload,     32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Cold load then sibling word hit.
        expect_xfer(1'b0, 32'h100, 32'h0);
        expect_xfer(1'b0, 32'h104, 32'h0);
        access("cold100", 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 7);
        access("hit104",  1'b1, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 0);

        // Store hit, no traffic; then idle outputs and read-back.
        access("st100", 1'b0, 1'b1, 32'h100, 32'h1234_5678, 32'h0, 0);
        #1;
        chk("idle_dhit",     32'(bus.dhit), 32'd0);
        chk("idle_dmemload", bus.dmemload,  32'd0);
        access("ld100", 1'b1, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0);

        // Three tags in set 0: second fills the other way, third evicts dirty 0x100.
        expect_xfer(1'b0, 32'h140, 32'h0);
        expect_xfer(1'b0, 32'h144, 32'h0);
        access("ld140", 1'b1, 1'b0, 32'h140, 32'h0, dflt(32'h140), 7);
        expect_xfer(1'b1, 32'h100, 32'h1234_5678);
        expect_xfer(1'b1, 32'h104, 32'hCAFE_F00D);
        expect_xfer(1'b0, 32'h180, 32'h0);
        expect_xfer(1'b0, 32'h184, 32'h0);
        access("ld180", 1'b1, 1'b0, 32'h180, 32'h0, dflt(32'h180), 13);
        access("hit140", 1'b1, 1'b0, 32'h140, 32'h0, dflt(32'h140), 0);

        // Both enables high on a hit behaves as a store.
        access("both144", 1'b1, 1'b1, 32'h144, 32'hA1B2_C3D4, 32'h0, 0);
        access("ld144",   1'b1, 1'b0, 32'h144, 32'h0, 32'hA1B2_C3D4, 0);

        // Store misses dirty two more frames (way 0 of sets 1 and 3).
        expect_xfer(1'b0, 32'h208, 32'h0);
        expect_xfer(1'b0, 32'h20C, 32'h0);
        access("st208", 1'b0, 1'b1, 32'h208, 32'h0BAD_F00D, 32'h0, 7);
        expect_xfer(1'b0, 32'h318, 32'h0);
        expect_xfer(1'b0, 32'h31C, 32'h0);
        access("st31c", 1'b0, 1'b1, 32'h31C, 32'h600D_CAFE, 32'h0, 7);
        chk("pre_flush_q", 32'(exp_q.size()), 32'd0);

        // Flush: dirty frames written back in way-major frame order.
        expect_xfer(1'b1, 32'h208, 32'h0BAD_F00D);
        expect_xfer(1'b1, 32'h20C, dflt(32'h20C));
        expect_xfer(1'b1, 32'h318, dflt(32'h318));
        expect_xfer(1'b1, 32'h31C, 32'h600D_CAFE);
        expect_xfer(1'b1, 32'h140, dflt(32'h140));
        expect_xfer(1'b1, 32'h144, 32'hA1B2_C3D4);
        @(negedge CLK);
        bus.halt = 1'b1;
        n = 0;
        #1;
        while (!bus.flushed && n < 400) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("flushed",       32'(bus.flushed),    32'd1);
        chk("flush_q_empty", 32'(exp_q.size()),   32'd0);

        // DONE ignores requests and keeps flushed high.
        @(negedge CLK);
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("done_dhit", 32'(bus.dhit), 32'd0);
            chk("done_dren", 32'(bus.dREN), 32'd0);
            @(negedge CLK);
        end
        #1;
        chk("flushed_sticky", 32'(bus.flushed), 32'd1);

        // Reset clears flushed.
        @(negedge CLK);
        bus.dmemREN = 1'b0;
        bus.halt    = 1'b0;
        RST         = 1'b1;
        #1;
        chk("rst2_flushed", 32'(bus.flushed), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Reset during LD1 drops dREN at once; the block misses again afterwards.
        mem_wait = 6;
        expect_xfer(1'b0, 32'h100, 32'h0);
        @(negedge CLK);
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h100;
        n = 0;
        #1;
        while (!(bus.dREN && bus.daddr == 32'h104) && n < 60) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("ld1_reached", 32'(bus.dREN && bus.daddr == 32'h104), 32'd1);
        RST = 1'b1;
        #1;
        chk("rst_ld1_dren",  32'(bus.dREN), 32'd0);
        chk("rst_ld1_dwen",  32'(bus.dWEN), 32'd0);
        chk("rst_ld1_daddr", bus.daddr,     32'd0);
        @(negedge CLK);
        RST         = 1'b0;
        bus.dmemREN = 1'b0;
        mem_wait    = 2;
        expect_xfer(1'b0, 32'h100, 32'h0);
        expect_xfer(1'b0, 32'h104, 32'h0);
        access("reload100", 1'b1, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 7);
        access("rehit104",  1'b1, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 0);

        repeat (3) @(negedge CLK);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dcache_wb2way.md
Name: dcache_wb2way

Overview:
- Write-back, 2-way set-associative data cache. It sits directly downstream of the pipeline MEM stage.
- It consumes the datapath's dmemREN/dmemWEN/dmemaddr/dmemstore/halt, and returns dhit/dmemload/flushed.
- Misses and write-backs go to the memory controller through a word-wide dREN/dWEN/dwait port.
- On halt, every dirty block is written back before flushed is raised.

Parameters:
- NSETS, 8, number of sets; must be a power of two ≥ 2. IDXW = log2(NSETS).

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- dmemREN  in  1  datapath load request
- dmemWEN  in  1  datapath store request
- dmemaddr  in  32  byte address; bits [1:0] are ignored
- dmemstore  in  32  store data
- halt  in  1  pipeline halted; begin flush
- dhit  out  1  request satisfied this cycle
- dmemload  out  32  load data, valid when dhit=1 and dmemREN=1
- flushed  out  1  flush complete; sticky until reset
- dREN  out  1  memory read request
- dWEN  out  1  memory write request
- daddr  out  32  memory word address (byte-aligned)
- dstore  out  32  memory write data
- dwait  in  1  memory busy; the transfer completes in the first cycle dwait=0
- dload  in  32  memory read data

Behaviour:
- One clock CLK. Reset RST is asynchronous and active-high.
- Reset clears all valid, dirty and LRU bits and sets state=IDLE. Outputs under reset: dhit=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0, dmemload=0. Data/tag arrays need no reset.
- Assertion of RST mid-transfer drops dREN/dWEN immediately; the partially loaded frame is never marked valid.
- Address split: tag=[31:IDXW+3], idx=[IDXW+2:3], blkoff=[2].
- Frame contents: valid, dirty, tag, word[2]. One LRU bit per set names the way to evict next.
- Hit (state IDLE only): a request is pending and a way has valid && tag match.
  - dhit=1 combinationally in the same cycle.
  - dmemload = word[blkoff] of the hitting way.
  - Store hit: word and dirty=1 update on that edge.
  - Every hit sets LRU = the other way.
- dmemREN and dmemWEN both high: treated as a store.
- No request: dhit=0, dmemload=0.
- Miss: victim = LRU way. Victim dirty → WB0; clean → LD0. dhit stays 0 until the refilled frame hits from IDLE.
- WB0: dWEN=1, daddr={victim tag, idx, 3'b000}, dstore=word0. On !dwait → WB1.
- WB1: same transfer, with address +4 and word1. On !dwait → LD0.
- LD0: dREN=1, daddr={req tag, idx, 3'b000}. On !dwait capture dload into word0 → LD1.
- LD1: address +4. On !dwait capture word1; set valid=1, dirty=0, tag=req tag → IDLE. The request hits on the next cycle (miss latency = 2 or 4 transfers + 1).
- Requests arriving while not in IDLE are ignored. The datapath holds them stable until dhit.
- halt:
  - Sampled only in IDLE. If halt=1 and no request is pending → FL_CHK with counter fi=0.
  - A pending request completes first.
- Flush walk: fi covers 2*NSETS frames (way-major).
  - FL_CHK: dirty frame → FL_W0; otherwise fi+1.
  - FL_W0/FL_W1 write word0/word1 as in WB0/WB1, clear dirty, then fi+1.
  - After the last frame → DONE: flushed=1. DONE ignores all requests and is left only by reset.
- Simultaneous dwait deassert and RST: reset wins.
- Only one of dREN/dWEN is ever high at a time.

Decomposition:
- Shared cache package holds:
  - dcache_state_t enum (IDLE, WB0, WB1, LD0, LD1, FL_CHK, FL_W0, FL_W1, DONE).
  - Packed dcache_addr_t (tag/idx/blkoff/bytoff).
  - dcache_frame_t struct.
- One sub-module, dcache_array: storage of frames and LRU, with two write ports (hit update and refill). Tags are compared in the top module.

Test Plan:
- Cold load 0x0000_0100, mem returns 0xDEAD_BEEF / 0xCAFE_F00D with dwait=1 for 2 cycles each → two dREN transfers at 0x100 and 0x104; then dhit=1 with dmemload=0xDEAD_BEEF; load 0x104 hits at once with 0xCAFE_F00D.
- Store 0x1234_5678 to 0x100 after fill → dhit same cycle, no memory traffic; load 0x100 returns 0x1234_5678.
- Same set, three tags (0x100, 0x140, 0x180 with NSETS=8), first dirtied → third access writes back 0x100/0x104 with stored data, then loads 0x180/0x184; 0x140 still hits.
- halt with 3 dirty frames → exactly 6 dWEN transfers in frame order, then flushed=1 stays high; later dmemREN gives dhit=0.
- RST pulsed during LD1 → dREN falls same cycle; after release, load of the same address misses again (2 dREN transfers).
- dmemREN=dmemWEN=1 on a hit → treated as a store: data written, dirty set.
